mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues data-bus requests and builds writeback records.
// Optional MEM_MISALIGN_CHECK_EN traps size-misaligned memory records.
module mem_access #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_pc,
  input  logic [ADDR_W-1:0] in_alu_out,
  input  logic [63:0]       in_wdata,
  input  logic [4:0]        in_dst,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic              in_regwrite,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [7:0]        dreq_strobe,
  output logic [63:0]       dreq_data,
  input  logic              dresp_ok,
  input  logic [63:0]       dresp_data,
  output logic              out_valid,
  output logic [63:0]       out_pc,
  output logic [63:0]       out_result,
  output logic [4:0]        out_dst,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic              out_misalign,
`endif
  output logic              out_wen
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              load_q;
  logic              wen_q;
  logic [63:0]       pc_q;
  logic [4:0]        dst_q;

  logic              dvalid_q;
  logic [ADDR_W-1:0] daddr_q;
  logic [7:0]        dstrb_q;
  logic [63:0]       ddata_q;
  logic              ovalid_q;
  logic [63:0]       opc_q;
  logic [63:0]       ores_q;
  logic [4:0]        odst_q;
  logic              owen_q;

  logic              is_mem;
  logic [2:0]        off;
  logic [7:0]        mask;
  logic [7:0]        strobe_d;
  logic [63:0]       wdata_d;
  logic [63:0]       shifted;
  logic [63:0]       load_d;

  assign in_ready    = (state_q == S_IDLE);
  assign dreq_valid  = dvalid_q;
  assign dreq_addr   = daddr_q;
  assign dreq_strobe = dstrb_q;
  assign dreq_data   = ddata_q;
  assign out_valid   = ovalid_q;
  assign out_pc      = opc_q;
  assign out_result  = ores_q;
  assign out_dst     = odst_q;
  assign out_wen     = owen_q;

  always_comb begin
    is_mem = in_memread | in_memwrite;
    off    = in_alu_out[2:0];
    mask   = 8'hFF;
    unique case (in_size)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    // loads never drive strobes, even if memwrite is also set
    strobe_d = 8'h00;
    if (in_memwrite && !in_memread)
      strobe_d = mask << off;
    wdata_d = in_wdata << {off, 3'b000};
    shifted = dresp_data >> {addr_q[2:0], 3'b000};
    load_d  = shifted;
    unique case (size_q)
      2'd0: load_d = uns_q ? {56'd0, shifted[7:0]}
                           : {{56{shifted[7]}}, shifted[7:0]};
      2'd1: load_d = uns_q ? {48'd0, shifted[15:0]}
                           : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_d = uns_q ? {32'd0, shifted[31:0]}
                           : {{32{shifted[31]}}, shifted[31:0]};
      default: load_d = shifted;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic       mis_d;
  logic       omis_q;
  logic [2:0] amask;

  always_comb begin
    amask = 3'd0;
    unique case (in_size)
      2'd0:    amask = 3'd0;
      2'd1:    amask = 3'd1;
      2'd2:    amask = 3'd3;
      default: amask = 3'd7;
    endcase
    mis_d = |(off & amask);
  end

  assign out_misalign = omis_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      load_q   <= 1'b0;
      wen_q    <= 1'b0;
      pc_q     <= 64'd0;
      dst_q    <= 5'd0;
      dvalid_q <= 1'b0;
      daddr_q  <= '0;
      dstrb_q  <= 8'd0;
      ddata_q  <= 64'd0;
      ovalid_q <= 1'b0;
      opc_q    <= 64'd0;
      ores_q   <= 64'd0;
      odst_q   <= 5'd0;
      owen_q   <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      omis_q   <= 1'b0;
`endif
    end else begin
      ovalid_q <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      omis_q   <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              ovalid_q <= 1'b1;
              opc_q    <= in_pc;
              ores_q   <= 64'(in_alu_out);
              odst_q   <= in_dst;
              owen_q   <= in_regwrite && (in_dst != 5'd0);
            end
`ifdef MEM_MISALIGN_CHECK_EN
            else if (mis_d) begin
              ovalid_q <= 1'b1;
              opc_q    <= in_pc;
              ores_q   <= 64'(in_alu_out);
              odst_q   <= in_dst;
              owen_q   <= 1'b0;
              omis_q   <= 1'b1;
            end
`endif
            else begin
              state_q  <= S_WAIT;
              addr_q   <= in_alu_out;
              size_q   <= in_size;
              uns_q    <= in_unsigned;
              load_q   <= in_memread;
              wen_q    <= in_regwrite && (in_dst != 5'd0);
              pc_q     <= in_pc;
              dst_q    <= in_dst;
              dvalid_q <= 1'b1;
              daddr_q  <= in_alu_out;
              dstrb_q  <= strobe_d;
              ddata_q  <= wdata_d;
            end
          end
        end
        S_WAIT: begin
          if (dresp_ok) begin
            state_q  <= S_IDLE;
            dvalid_q <= 1'b0;
            ovalid_q <= 1'b1;
            opc_q    <= pc_q;
            odst_q   <= dst_q;
            owen_q   <= load_q && wen_q;
            ores_q   <= load_q ? load_d : 64'(addr_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed-vector bench for mem_access.
// Expected values are hand-computed from the stage's behaviour.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_alu_out;
  logic [63:0] in_wdata;
  logic [4:0]  in_dst;
  logic        in_memread;
  logic        in_memwrite;
  logic        in_regwrite;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_ok;
  logic [63:0] dresp_data;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_result;
  logic [4:0]  out_dst;
  logic        out_wen;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        out_misalign;
`endif

  int nvec = 0;
  int nerr = 0;
  int pulses = 0;
  int p0;

  mem_access #(.ADDR_W(64)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_alu_out(in_alu_out),
    .in_wdata(in_wdata),
    .in_dst(in_dst),
    .in_memread(in_memread),
    .in_memwrite(in_memwrite),
    .in_regwrite(in_regwrite),
    .in_size(in_size),
    .in_unsigned(in_unsigned),
    .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr),
    .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data),
    .dresp_ok(dresp_ok),
    .dresp_data(dresp_data),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_result(out_result),
    .out_dst(out_dst),
`ifdef MEM_MISALIGN_CHECK_EN
    .out_misalign(out_misalign),
`endif
    .out_wen(out_wen)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (out_valid) pulses++;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [63:0] pc, input logic [63:0] a,
                     input logic [63:0] wd, input logic [4:0] dst,
                     input logic rd, input logic wr, input logic rw,
                     input logic [1:0] sz, input logic un);
    int n;
    in_pc = pc;
    in_alu_out = a;
    in_wdata = wd;
    in_dst = dst;
    in_memread = rd;
    in_memwrite = wr;
    in_regwrite = rw;
    in_size = sz;
    in_unsigned = un;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick(1);
      n++;
    end
    if (n == 20) chk("ready_timeout", 64'd0, 64'd1);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic resp(input int dly, input logic [63:0] a,
                      input logic [63:0] d);
    repeat (dly) begin
      chk("hold_valid", 64'(dreq_valid), 64'd1);
      chk("hold_addr", dreq_addr, a);
      chk("hold_noout", 64'(out_valid), 64'd0);
      tick(1);
    end
    dresp_ok = 1'b1;
    dresp_data = d;
    tick(1);
    dresp_ok = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [63:0] a,
                    input logic [1:0] sz, input logic un,
                    input logic [63:0] d, input logic [63:0] exp);
    put(64'h200, a, 64'd0, 5'd7, 1'b1, 1'b0, 1'b1, sz, un);
    chk({tag, "_strb"}, 64'(dreq_strobe), 64'd0);
    resp(1, a, d);
    chk({tag, "_ov"}, 64'(out_valid), 64'd1);
    chk({tag, "_res"}, out_result, exp);
    chk({tag, "_wen"}, 64'(out_wen), 64'd1);
    tick(1);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_pc = '0;
    in_alu_out = '0;
    in_wdata = '0;
    in_dst = '0;
    in_memread = 1'b0;
    in_memwrite = 1'b0;
    in_regwrite = 1'b0;
    in_size = '0;
    in_unsigned = 1'b0;
    dresp_ok = 1'b0;
    dresp_data = '0;
    tick(2);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_dvalid", 64'(dreq_valid), 64'd0);
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_strobe", 64'(dreq_strobe), 64'd0);
    chk("rst_wen", 64'(out_wen), 64'd0);
    reset = 1'b0;
    tick(1);

    // non-memory record
    put(64'h40, 64'd5, 64'd0, 5'd3, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    chk("alu_ov", 64'(out_valid), 64'd1);
    chk("alu_res", out_result, 64'd5);
    chk("alu_dst", 64'(out_dst), 64'd3);
    chk("alu_wen", 64'(out_wen), 64'd1);
    chk("alu_pc", out_pc, 64'h40);
    chk("alu_noreq", 64'(dreq_valid), 64'd0);
    tick(1);
    chk("alu_pulse", 64'(out_valid), 64'd0);

    put(64'h44, 64'd9, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    chk("x0_ov", 64'(out_valid), 64'd1);
    chk("x0_wen", 64'(out_wen), 64'd0);
    tick(2);

    // dword load, 3 wait cycles
    p0 = pulses;
    put(64'h100, 64'h80000008, 64'd0, 5'd10, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    chk("ldd_req", 64'(dreq_valid), 64'd1);
    chk("ldd_busy", 64'(in_ready), 64'd0);
    resp(3, 64'h80000008, 64'h1122334455667788);
    chk("ldd_ov", 64'(out_valid), 64'd1);
    chk("ldd_res", out_result, 64'h1122334455667788);
    chk("ldd_wen", 64'(out_wen), 64'd1);
    chk("ldd_pc", out_pc, 64'h100);
    chk("ldd_dst", 64'(out_dst), 64'd10);
    chk("ldd_dreq", 64'(dreq_valid), 64'd0);
    tick(3);
    chk("ldd_once", 64'(pulses - p0), 64'd1);

    ld("lbs", 64'h1003, 2'd0, 1'b0, 64'h80000000, 64'hFFFFFFFFFFFFFF80);
    ld("lbu", 64'h1003, 2'd0, 1'b1, 64'h80000000, 64'h80);
    ld("lhs", 64'h1002, 2'd1, 1'b0, 64'h80000000, 64'hFFFFFFFFFFFF8000);
    ld("lwu", 64'h1004, 2'd2, 1'b1, 64'hDEADBEEF00000000, 64'hDEADBEEF);
    ld("lws", 64'h1004, 2'd2, 1'b0, 64'hDEADBEEF00000000, 64'hFFFFFFFFDEADBEEF);

    // stores
    put(64'h300, 64'h2006, 64'hABCD, 5'd4, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    chk("sh_strb", 64'(dreq_strobe), 64'hC0);
    chk("sh_data", dreq_data, 64'hABCD000000000000);
    resp(2, 64'h2006, 64'd0);
    chk("sh_ov", 64'(out_valid), 64'd1);
    chk("sh_wen", 64'(out_wen), 64'd0);
    tick(1);

    put(64'h304, 64'h2007, 64'h5A, 5'd4, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("sb_strb", 64'(dreq_strobe), 64'h80);
    chk("sb_data", dreq_data, 64'h5A00000000000000);
    resp(1, 64'h2007, 64'd0);
    tick(1);

    put(64'h308, 64'h2004, 64'h1122334455667788, 5'd4,
        1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
`ifdef MEM_MISALIGN_CHECK_EN
    chk("mis_noreq", 64'(dreq_valid), 64'd0);
    chk("mis_ov", 64'(out_valid), 64'd1);
    chk("mis_flag", 64'(out_misalign), 64'd1);
    chk("mis_wen", 64'(out_wen), 64'd0);
    chk("mis_ready", 64'(in_ready), 64'd1);
`else
    chk("sdm_strb", 64'(dreq_strobe), 64'hF0);
    chk("sdm_data", dreq_data, 64'h5566778800000000);
    resp(1, 64'h2004, 64'd0);
`endif
    tick(2);

    // response while idle is ignored
    dresp_ok = 1'b1;
    dresp_data = 64'h1234;
    tick(1);
    dresp_ok = 1'b0;
    chk("idle_ok_ov", 64'(out_valid), 64'd0);
    chk("idle_ok_rdy", 64'(in_ready), 64'd1);

    // back-to-back: second record held off until the response
    put(64'h500, 64'h3000, 64'd0, 5'd6, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    in_pc = 64'h504;
    in_alu_out = 64'h77;
    in_dst = 5'd5;
    in_memread = 1'b0;
    in_memwrite = 1'b0;
    in_regwrite = 1'b1;
    in_valid = 1'b1;
    chk("b2b_hold", 64'(in_ready), 64'd0);
    tick(1);
    chk("b2b_hold2", 64'(in_ready), 64'd0);
    chk("b2b_addr", dreq_addr, 64'h3000);
    dresp_ok = 1'b1;
    dresp_data = 64'hCAFE;
    tick(1);
    dresp_ok = 1'b0;
    chk("b2b_ov1", 64'(out_valid), 64'd1);
    chk("b2b_res1", out_result, 64'hCAFE);
    chk("b2b_dst1", 64'(out_dst), 64'd6);
    chk("b2b_noreq", 64'(dreq_valid), 64'd0);
    tick(1);
    in_valid = 1'b0;
    chk("b2b_ov2", 64'(out_valid), 64'd1);
    chk("b2b_res2", out_result, 64'h77);
    chk("b2b_dst2", 64'(out_dst), 64'd5);
    tick(2);

    // reset in the middle of a wait
    p0 = pulses;
    put(64'h600, 64'h4000, 64'd0, 5'd8, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    chk("rw_req", 64'(dreq_valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("rw_dvalid", 64'(dreq_valid), 64'd0);
    chk("rw_addr", dreq_addr, 64'd0);
    chk("rw_ready", 64'(in_ready), 64'd1);
    tick(1);
    reset = 1'b0;
    dresp_ok = 1'b1;
    dresp_data = 64'h99;
    tick(1);
    dresp_ok = 1'b0;
    tick(3);
    chk("rw_nopulse", 64'(pulses - p0), 64'd0);
    chk("rw_ready2", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
